// File: rtl/panel_scan_timing.sv
`default_nettype none
// ============================================================================
// Module : panel_scan_timing
// Desc   : Row scan sequencer for shift-register LED panels (linear PWM / BCM).
// Rev    : 1.0  initial release
// ============================================================================
module panel_scan_timing #(
  parameter int COL_WIDTH    = 6,
  parameter int ROW_WIDTH    = 3,
  parameter int PWM_WIDTH    = 12,
  parameter int UNIT         = 1,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 swap_req,
  output logic [COL_WIDTH-1:0] col,
  output logic [ROW_WIDTH-1:0] line,
  output logic [PWM_WIDTH-1:0] pwm,
  output logic                 shift_en,
  output logic                 lat,
  output logic                 oe_n,
  output logic                 frame_clk,
  output logic                 swap_ack
);

  localparam int CNT_W = $clog2(UNIT) + PWM_WIDTH + 1;
  localparam int BLK_W = $clog2(BLANK_CYCLES) + 1;

  localparam logic [COL_WIDTH-1:0] c_COL_MAX   = '1;
  localparam logic [ROW_WIDTH-1:0] c_LINE_MAX  = '1;
  localparam logic [PWM_WIDTH-1:0] c_PWM_MAX   = '1;
  localparam logic [PWM_WIDTH-1:0] c_PLANE_MAX = PWM_WIDTH'(PWM_WIDTH - 1);
  localparam logic [CNT_W-1:0]     c_UNIT      = CNT_W'(UNIT);
  localparam logic [CNT_W-1:0]     c_ONE       = CNT_W'(1);
  localparam logic [BLK_W-1:0]     c_BLK_LOAD  = BLK_W'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_LATCH = 3'd2,
    S_BLANK = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_mode;
  logic [CNT_W-1:0]   r_show_cnt;
  logic [BLK_W-1:0]   r_blank_cnt;

  logic [CNT_W-1:0]     w_show_len;
  logic                 w_last_row;
  logic [PWM_WIDTH-1:0] w_pwm_next;

  // In BCM mode pwm carries the plane index, so it also sets the SHOW weight.
  assign w_show_len = r_mode ? (c_UNIT << pwm) : c_UNIT;
  assign w_last_row = (line == c_LINE_MAX) &&
                      (r_mode ? (pwm == c_PLANE_MAX) : (pwm == c_PWM_MAX));
  assign w_pwm_next = (r_mode && (pwm == c_PLANE_MAX)) ? '0 : pwm + 1'b1;

  // Grant follows the live request so it tracks swap_req within the frame-end cycle.
  assign swap_ack = frame_clk & swap_req;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_show_cnt  <= '0;
      r_blank_cnt <= '0;
      col         <= '0;
      line        <= '0;
      pwm         <= '0;
      shift_en    <= 1'b0;
      lat         <= 1'b0;
      oe_n        <= 1'b1;
      frame_clk   <= 1'b0;
    end else begin
      lat       <= 1'b0;
      frame_clk <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state  <= S_SHIFT;
            r_mode   <= mode;
            col      <= '0;
            line     <= '0;
            pwm      <= '0;
            shift_en <= 1'b1;
          end
        end
        S_SHIFT: begin
          col <= col + 1'b1;
          if (col == c_COL_MAX) begin
            r_state  <= S_LATCH;
            shift_en <= 1'b0;
            lat      <= 1'b1;
          end
        end
        S_LATCH: begin
          r_state     <= S_BLANK;
          r_blank_cnt <= c_BLK_LOAD;
        end
        S_BLANK: begin
          if (r_blank_cnt == '0) begin
            r_state    <= S_SHOW;
            oe_n       <= 1'b0;
            r_show_cnt <= w_show_len - c_ONE;
            frame_clk  <= w_last_row && (w_show_len == c_ONE);
          end else begin
            r_blank_cnt <= r_blank_cnt - 1'b1;
          end
        end
        S_SHOW: begin
          if (r_show_cnt == '0) begin
            oe_n <= 1'b1;
            col  <= '0;
            if (frame_clk) begin
              // Frame boundary: the only point besides IDLE exit where mode is resampled.
              line   <= '0;
              pwm    <= '0;
              r_mode <= mode;
              if (enable) begin
                r_state  <= S_SHIFT;
                shift_en <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              line     <= line + 1'b1;
              r_state  <= S_SHIFT;
              shift_en <= 1'b1;
              if (line == c_LINE_MAX) begin
                pwm <= w_pwm_next;
              end
            end
          end else begin
            r_show_cnt <= r_show_cnt - 1'b1;
            frame_clk  <= w_last_row && (r_show_cnt == c_ONE);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          shift_en <= 1'b0;
          oe_n     <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_panel_scan_timing.sv
`default_nettype none
// ============================================================================
// Module : tb_panel_scan_timing
// Desc   : Self-checking bench for panel_scan_timing against a frame-schedule model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_panel_scan_timing;

  localparam int CW = 2;
  localparam int RW = 1;
  localparam int PW = 2;
  localparam int UN = 1;
  localparam int BL = 1;
  localparam int NC = 1 << CW;
  localparam int NL = 1 << RW;

  logic          clk_in = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic          swap_req = 1'b0;
  logic [CW-1:0] col;
  logic [RW-1:0] line;
  logic [PW-1:0] pwm;
  logic          shift_en, lat, oe_n, frame_clk, swap_ack;

  panel_scan_timing #(
    .COL_WIDTH(CW), .ROW_WIDTH(RW), .PWM_WIDTH(PW), .UNIT(UN), .BLANK_CYCLES(BL)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .mode(mode),
    .swap_req(swap_req), .col(col), .line(line), .pwm(pwm),
    .shift_en(shift_en), .lat(lat), .oe_n(oe_n), .frame_clk(frame_clk),
    .swap_ack(swap_ack)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [CW-1:0] col;
    logic [RW-1:0] line;
    logic [PW-1:0] pwm;
    logic          sh;
    logic          lat;
    logic          oe_n;
    logic          fc;
    logic          ack;
  } exp_t;

  typedef struct {
    bit   md;
    int   cyc;
    exp_t e;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  bit m_run = 0;
  int m_t = 0;
  bit m_mode = 0;

  function automatic int show_len(bit md, int r);
    return md ? (UN << (r / NL)) : UN;
  endfunction

  function automatic int n_rows(bit md);
    return (md ? PW : (1 << PW)) * NL;
  endfunction

  function automatic int frame_len(bit md);
    int s = 0;
    for (int r = 0; r < n_rows(md); r++) s += NC + 1 + BL + show_len(md, r);
    return s;
  endfunction

  function automatic exp_t mk(int c, int l, int p, bit sh, bit la, bit oe, bit fc);
    exp_t e;
    e.col = CW'(c); e.line = RW'(l); e.pwm = PW'(p);
    e.sh = sh; e.lat = la; e.oe_n = oe; e.fc = fc; e.ack = 1'b0;
    return e;
  endfunction

  // Expected outputs at cycle t of a frame, derived from the row schedule.
  function automatic exp_t model_out(bit run, int t, bit md, bit sreq);
    exp_t e;
    int   off, len;
    bit   found;
    e = mk(0, 0, 0, 0, 0, 1, 0);
    off = t;
    found = 0;
    if (run) begin
      for (int r = 0; r < n_rows(md); r++) begin
        len = NC + 1 + BL + show_len(md, r);
        if (!found && off < len) begin
          found  = 1;
          e.line = RW'(r % NL);
          e.pwm  = PW'(r / NL);
          if (off < NC) begin
            e.sh = 1'b1; e.col = CW'(off);
          end else if (off == NC) begin
            e.lat = 1'b1;
          end else if (off >= NC + 1 + BL) begin
            e.oe_n = 1'b0;
            if (r == n_rows(md) - 1 && off == len - 1) begin
              e.fc = 1'b1; e.ack = sreq;
            end
          end
        end
        if (!found) off -= len;
      end
    end
    return e;
  endfunction

  task automatic compare(string tag, exp_t e);
    logic [$bits(exp_t)-1:0] act, ex;
    act = {e.sh ? col : {CW{1'b0}}, line, pwm, shift_en, lat, oe_n, frame_clk, swap_ack};
    ex  = e;
    n_vec++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %b want %b (col,line,pwm,sh,lat,oe_n,fc,ack)",
               tag, cyc, act, ex);
    end
  endtask

  task automatic check_int(string tag, int act, int ex);
    n_vec++;
    if (act != ex) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, ex);
    end
  endtask

  // Advance the model with the inputs the next posedge will see, then check.
  task automatic tick(string tag);
    if (!m_run) begin
      if (enable) begin m_run = 1; m_t = 0; m_mode = mode; end
    end else if (m_t == frame_len(m_mode) - 1) begin
      if (enable) begin m_t = 0; m_mode = mode; end
      else m_run = 0;
    end else begin
      m_t++;
    end
    @(negedge clk_in);
    cyc++;
    compare(tag, model_out(m_run, m_t, m_mode, swap_req));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; swap_req = 1'b0; mode = 1'b0;
    m_run = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    compare("reset", model_out(0, 0, 0, 0));
    reset_n = 1'b1;
  endtask

  task automatic start_run(bit md);
    mode = md; enable = 1'b1; cyc = -1;
    tick("start");
  endtask

  vec_t tbl[16];
  int   ack_cnt, ack_at, fc_at, sh_cnt;

  initial begin
    tbl[0]  = '{0, 0,  mk(0, 0, 0, 1, 0, 1, 0)};
    tbl[1]  = '{0, 3,  mk(3, 0, 0, 1, 0, 1, 0)};
    tbl[2]  = '{0, 4,  mk(0, 0, 0, 0, 1, 1, 0)};
    tbl[3]  = '{0, 5,  mk(0, 0, 0, 0, 0, 1, 0)};
    tbl[4]  = '{0, 6,  mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{0, 13, mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[6]  = '{0, 14, mk(0, 0, 1, 1, 0, 1, 0)};
    tbl[7]  = '{0, 55, mk(0, 1, 3, 0, 0, 0, 1)};
    tbl[8]  = '{0, 56, mk(0, 0, 0, 1, 0, 1, 0)};
    tbl[9]  = '{1, 6,  mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{1, 20, mk(0, 0, 1, 0, 0, 0, 0)};
    tbl[11] = '{1, 21, mk(0, 0, 1, 0, 0, 0, 0)};
    tbl[12] = '{1, 22, mk(0, 1, 1, 1, 0, 1, 0)};
    tbl[13] = '{1, 28, mk(0, 1, 1, 0, 0, 0, 0)};
    tbl[14] = '{1, 29, mk(0, 1, 1, 0, 0, 0, 1)};
    tbl[15] = '{1, 30, mk(0, 0, 0, 1, 0, 1, 0)};

    @(negedge clk_in);
    for (int i = 0; i < 16; i++) begin
      do_reset();
      start_run(tbl[i].md);
      while (cyc < tbl[i].cyc) tick("tbl_run");
      compare("tbl", tbl[i].e);
    end

    // Swap request raised mid-frame and held: one grant at frame end only.
    do_reset();
    start_run(0);
    ack_cnt = 0; ack_at = -1;
    while (cyc < 111) begin
      if (cyc == 10) swap_req = 1'b1;
      if (cyc == 56) swap_req = 1'b0;
      tick("swap");
      if (swap_ack) begin ack_cnt++; ack_at = cyc; end
    end
    check_int("swap_ack_count", ack_cnt, 1);
    check_int("swap_ack_cycle", ack_at, 55);

    // Enable dropped mid-frame: frame completes, then idle.
    do_reset();
    start_run(0);
    fc_at = -1; sh_cnt = 0;
    while (cyc < 70) begin
      if (cyc == 20) enable = 1'b0;
      tick("en_drop");
      if (frame_clk) fc_at = cyc;
      if (cyc >= 56 && (shift_en || !oe_n)) sh_cnt++;
    end
    check_int("en_drop_frame_clk", fc_at, 55);
    check_int("en_drop_idle_activity", sh_cnt, 0);

    // Asynchronous reset inside the LATCH cycle of line 1.
    do_reset();
    start_run(0);
    while (cyc < 11) tick("rst_run");
    check_int("pre_reset_lat", int'(lat), 1);
    #2 reset_n = 1'b0;
    #1 compare("async_reset", mk(0, 0, 0, 0, 0, 1, 0));
    m_run = 0;
    @(negedge clk_in);
    reset_n = 1'b1;
    tick("post_reset_first_shift");
    check_int("post_reset_shift_en", int'(shift_en), 1);

    // Mode flipped mid-frame: mode-0 frame completes, next frame is BCM.
    do_reset();
    start_run(0);
    fc_at = 0;
    while (cyc < 90) begin
      if (cyc == 10) mode = 1'b1;
      tick("mode_flip");
      if (frame_clk && cyc > 56) fc_at = cyc;
    end
    check_int("mode_flip_bcm_frame_end", fc_at, 56 + 29);

    // Randomized inputs against the schedule model.
    do_reset();
    cyc = 0;
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      mode     = 1'($urandom_range(0, 1));
      swap_req = 1'($urandom_range(0, 1));
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
